// File: rtl/drac_pkg.sv
// Shared types for the execute-stage branch resolution slice.
//   - exe_wb_scalar_instr_t : branch unit output consumed by branch_resolve_unit
//   - bp_update_t           : predictor training record {pc, target, taken, is_cond}
//   - resolve_state_t       : redirect FSM states
//   - branch_redirect_t     : latched redirect payload {pc, chkp, gl_index}
package drac_pkg;

  typedef logic [1:0] checkpoint_ptr;
  typedef logic [5:0] gl_index_t;

  typedef enum logic [3:0] {
    INSTR_OTHER,
    BEQ,
    BNE,
    BLT,
    BGE,
    BLTU,
    BGEU,
    JAL,
    JALR
  } instr_type_t;

  typedef enum logic {
    PRED_NOT_TAKEN,
    PRED_TAKEN
  } branch_pred_decision_t;

  typedef struct packed {
    branch_pred_decision_t decision;
    logic [63:0]           pred_addr;
  } bpred_t;

  typedef struct packed {
    logic [3:0]  cause;
    logic [63:0] origin;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic          valid;
    logic [63:0]   pc;
    bpred_t        bpred;
    logic          branch_taken;
    logic [63:0]   result_pc;
    instr_type_t   instr_type;
    checkpoint_ptr chkp;
    gl_index_t     gl_index;
    exception_t    ex;
  } exe_wb_scalar_instr_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] target;
    logic        taken;
    logic        is_cond;
  } bp_update_t;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } resolve_state_t;

  typedef struct packed {
    logic [63:0]   pc;
    checkpoint_ptr chkp;
    gl_index_t     gl_index;
  } branch_redirect_t;

  // Conditional branches only; jumps train the BTB but not the direction predictor.
  function automatic logic is_cond_branch(instr_type_t t);
    return (t == BEQ) || (t == BNE) || (t == BLT) ||
           (t == BGE) || (t == BLTU) || (t == BGEU);
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO for predictor-update records with a saturating drop counter.
//   push_i/data_i   : write request; dropped (and counted) when full and not popping
//   valid_o/ready_i : read handshake, data_o is the head entry
//   full_o/empty_o  : occupancy flags
//   drop_cnt_o      : number of dropped pushes, saturates at all-ones
// Registered storage only: a push becomes visible on valid_o the cycle after.
module bp_update_fifo
  import drac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  bp_update_t       data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output bp_update_t       data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  bp_update_t       mem_q [DEPTH];
  bp_update_t       mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             pop;
  logic             do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign drop_cnt_o = drop_cnt_q;

  assign pop     = valid_o & ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i & (~full_o | pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_i && !do_push && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: compares the resolved next PC against the front-end
// prediction, drives a held redirect to fetch and checkpoint recovery to rename
// on a mispredict, and queues a predictor-training record for every resolved,
// exception-free control-flow instruction.
//   instr_i              : branch unit output (sampled only in IDLE)
//   kill_i               : older flush, cancels any pending redirect
//   redirect_*           : valid/ready redirect request with payload
//   recover_*            : checkpoint and graduation-list index to restore
//   mispredict_o         : one-cycle pulse per mispredict
//   stall_o              : upstream holds its instruction (REDIRECT, FLUSH)
//   flush_younger_o      : one cycle after the redirect handshake
//   upd_*                : predictor-update stream and drop counter
//   debug_state_o        : current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never drops and payload never changes while waiting for ready,
// except when kill_i or rst_i abandons the request.
module branch_resolve_unit
  import drac_pkg::*;
#(
  parameter int UPD_FIFO_DEPTH = 4,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  exe_wb_scalar_instr_t  instr_i,
  input  logic                  kill_i,
  input  logic                  redirect_ready_i,
  output logic                  redirect_valid_o,
  output logic [63:0]           redirect_pc_o,
  output checkpoint_ptr         recover_chkp_o,
  output gl_index_t             recover_gl_index_o,
  output logic                  mispredict_o,
  output logic                  stall_o,
  output logic                  flush_younger_o,
  output logic                  upd_valid_o,
  input  logic                  upd_ready_i,
  output bp_update_t            upd_o,
  output logic [DROP_CNT_W-1:0] upd_drop_cnt_o,
  output resolve_state_t        debug_state_o
);

  resolve_state_t   state_q, state_d;
  branch_redirect_t redir_q, redir_d;
  logic             mispredict_q, mispredict_d;

  logic        qualify;
  logic [63:0] pc_plus4;
  logic [63:0] actual_npc;
  logic [63:0] pred_npc;
  logic        push;
  bp_update_t  upd_rec;
  logic        fifo_full;
  logic        fifo_empty;

  always_comb begin
    state_d      = state_q;
    redir_d      = redir_q;
    mispredict_d = 1'b0;
    push         = 1'b0;
    qualify      = instr_i.valid & ~instr_i.ex.valid & ~kill_i;
    // Wraps modulo 2^64, matching the fetch adder.
    pc_plus4     = instr_i.pc + 64'd4;
    actual_npc   = instr_i.branch_taken ? instr_i.result_pc : pc_plus4;
    pred_npc     = (instr_i.bpred.decision == PRED_TAKEN) ? instr_i.bpred.pred_addr : pc_plus4;
    upd_rec.pc      = instr_i.pc;
    upd_rec.target  = instr_i.result_pc;
    upd_rec.taken   = instr_i.branch_taken;
    upd_rec.is_cond = is_cond_branch(instr_i.instr_type);

    case (state_q)
      IDLE: begin
        push = qualify;
        if (qualify && (actual_npc != pred_npc)) begin
          state_d          = REDIRECT;
          redir_d.pc       = actual_npc;
          redir_d.chkp     = instr_i.chkp;
          redir_d.gl_index = instr_i.gl_index;
          mispredict_d     = 1'b1;
        end
      end
      REDIRECT: begin
        // kill_i wins over a same-cycle handshake: the redirect is wrong-path.
        if (kill_i) begin
          state_d = IDLE;
        end else if (redirect_ready_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      redir_q      <= '0;
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      redir_q      <= redir_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign redirect_valid_o   = (state_q == REDIRECT);
  assign redirect_pc_o      = redir_q.pc;
  assign recover_chkp_o     = redir_q.chkp;
  assign recover_gl_index_o = redir_q.gl_index;
  assign mispredict_o       = mispredict_q;
  assign stall_o            = (state_q != IDLE);
  assign flush_younger_o    = (state_q == FLUSH);
  assign debug_state_o      = state_q;

  bp_update_fifo #(
    .DEPTH (UPD_FIFO_DEPTH),
    .CNT_W (DROP_CNT_W)
  ) u_upd_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .data_i     (upd_rec),
    .valid_o    (upd_valid_o),
    .ready_i    (upd_ready_i),
    .data_o     (upd_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .drop_cnt_o (upd_drop_cnt_o)
  );

  // Flags are kept for visibility on the sub-module boundary; only the
  // handshake is consumed here.
  logic unused_flags;
  assign unused_flags = fifo_full ^ fifo_empty;

endmodule
